seq_signed_divider: RTL
=======================

SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=4).
REQ-002 SHALL have port clock  in  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  in  1  request; sampled only when busy=0.
REQ-005 SHALL have port signed_op  in  1  1=two's-complement divide, 0=unsigned divide; sampled with start.
REQ-006 SHALL have port dividend  in  WIDTH  numerator; sampled with start.
REQ-007 SHALL have port divisor  in  WIDTH  denominator; sampled with start.
REQ-008 SHALL have port busy  out  1  high from the cycle after accept until done falls.
REQ-009 SHALL have port done  out  1  one-cycle pulse; results valid.
REQ-010 SHALL have port quotient  out  WIDTH  registered quotient.
REQ-011 SHALL have port remainder  out  WIDTH  registered remainder.
REQ-012 SHALL have port div_zero  out  1  divisor was zero; valid with done, held.
REQ-013 SHALL have port overflow  out  1  present only under DIV_OVERFLOW_EN.

Function
REQ-014 SHALL implement FSM IDLE, CALC, FIX, DONE.
REQ-015 IDLE: start=1 SHALL latch operands, take magnitudes (signed_op=1) or raw values (0), record signs, go to CALC; divisor=0 goes directly to DONE.
REQ-016 CALC SHALL perform one restoring shift-subtract iteration per cycle, MSB first, for exactly WIDTH cycles, then go to FIX.
REQ-017 FIX SHALL negate quotient if operand signs differ and negate remainder if dividend negative (signed_op=1 only), then go to DONE.
REQ-018 DONE SHALL assert done for one cycle, load quotient/remainder/div_zero, return to IDLE.
REQ-019 Latency: done SHALL rise WIDTH+2 cycles after the accepting edge; divide-by-zero: 1 cycle.
REQ-020 Divide-by-zero SHALL give quotient all-ones, remainder = original dividend, div_zero=1.
REQ-021 Remainder sign SHALL follow dividend; |remainder| < |divisor|; dividend = quotient*divisor + remainder (mod 2^WIDTH).
REQ-022 Signed MIN / -1 SHALL give quotient MIN (wrap), remainder 0.
REQ-023 start while busy=1 SHALL be ignored; no queuing.
REQ-024 Outputs SHALL hold last results until the next DONE.
REQ-025 start in the DONE cycle SHALL be ignored; next accept earliest the following cycle.

Reset
REQ-026 reset_n low SHALL force IDLE and clear busy, done, quotient, remainder, div_zero, overflow and internal registers to 0, asynchronously.
REQ-027 Reset mid-operation SHALL abort without done; first post-reset start behaves as from power-up.

Configuration
REQ-028 With DIV_OVERFLOW_EN defined, overflow port SHALL exist and be 1 with done for signed MIN / -1, else 0, held like div_zero.
REQ-029 Without DIV_OVERFLOW_EN, overflow port and logic SHALL be absent; results unchanged.

Structure
REQ-030 Package div_pkg SHALL hold the FSM state typedef and DIV_WIDTH_DEFAULT=32.
REQ-031 Sub-module div_step SHALL implement one combinational restoring iteration (partial remainder, divisor, next bit -> new remainder, quotient bit), instantiated once.

Verification (WIDTH=32)
REQ-032 100 / 7, signed_op=1 -> quotient 14, remainder 2, done exactly 34 cycles after accept.
REQ-033 -100 / 7 -> 0xFFFFFFF2, 0xFFFFFFFE; 100 / -7 -> 0xFFFFFFF2, 2.
REQ-034 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000, remainder 0, overflow 1 (macro on); unsigned -> 0, 0x80000000.
REQ-035 5 / 0 -> quotient 0xFFFFFFFF, remainder 5, div_zero 1, done 1 cycle after accept.
REQ-036 0xFFFFFFFF / 2, signed_op=0 -> 0x7FFFFFFF, 1; start pulses during busy ignored.
REQ-037 Deassert reset_n at CALC cycle 10 -> outputs 0, no done; new 9 / 3 -> 3, 0 in 34 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential signed/unsigned divider.
// DIV_OVERFLOW_EN (optional macro) adds the signed MIN / -1 overflow flag.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_signed_divider_if.sv
// Request/result bundle for seq_signed_divider; overflow exists only with DIV_OVERFLOW_EN.
// master drives operands and start, slave (the divider) returns status and results.
interface seq_signed_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
`ifdef DIV_OVERFLOW_EN
  logic             overflow;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, overflow
  );
  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, overflow
  );
`else
  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );
  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
`endif
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < dvs_i always holds, so diff[WIDTH] is exactly the borrow
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, dvs_i};
    qbit_o  = ~diff[WIDTH];
    rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_signed_divider.sv
// Sequential restoring divider, done WIDTH+2 cycles after accept (1 cycle on divide-by-zero).
// start is ignored while busy; DIV_OVERFLOW_EN adds the overflow flag for signed MIN / -1.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input logic                 clock,
  input logic                 reset_n,
  seq_signed_divider_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dz_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_zero_q;
`ifdef DIV_OVERFLOW_EN
  logic             ovf_q;
  logic             overflow_q;
`endif

  logic             dvd_neg_d;
  logic             dvs_neg_d;
  logic [WIDTH-1:0] dvd_mag_d;
  logic [WIDTH-1:0] dvs_mag_d;
  logic [WIDTH-1:0] step_rem_d;
  logic             step_qbit_d;

  always_comb begin
    dvd_neg_d = bus.signed_op & bus.dividend[WIDTH-1];
    dvs_neg_d = bus.signed_op & bus.divisor[WIDTH-1];
    dvd_mag_d = dvd_neg_d ? -bus.dividend : bus.dividend;
    dvs_mag_d = dvs_neg_d ? -bus.divisor  : bus.divisor;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .dvs_i  (dvs_q),
    .bit_i  (quo_q[WIDTH-1]),
    .rem_o  (step_rem_d),
    .qbit_o (step_qbit_d)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
`ifdef DIV_OVERFLOW_EN
      ovf_q       <= 1'b0;
      overflow_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // busy stays high through the done cycle, so a start there is dropped
          if (done_q) begin
            busy_q <= 1'b0;
          end else if (bus.start && !busy_q) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            dvs_q     <= dvs_mag_d;
            neg_quo_q <= dvd_neg_d ^ dvs_neg_d;
            neg_rem_q <= dvd_neg_d;
`ifdef DIV_OVERFLOW_EN
            ovf_q     <= bus.signed_op && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                         && (bus.divisor == '1);
`endif
            if (bus.divisor == '0) begin
              quo_q   <= '1;
              rem_q   <= bus.dividend;
              dz_q    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              quo_q   <= dvd_mag_d;
              rem_q   <= '0;
              dz_q    <= 1'b0;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          quo_q <= {quo_q[WIDTH-2:0], step_qbit_d};
          rem_q <= step_rem_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (neg_quo_q) quo_q <= -quo_q;
          if (neg_rem_q) rem_q <= -rem_q;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q      <= 1'b1;
          quotient_q  <= quo_q;
          remainder_q <= rem_q;
          div_zero_q  <= dz_q;
`ifdef DIV_OVERFLOW_EN
          overflow_q  <= ovf_q;
`endif
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
`ifdef DIV_OVERFLOW_EN
  assign bus.overflow  = overflow_q;
`endif

endmodule
